// File: rtl/ofm_drain.sv
// Drains 16-lane PE pixel results through a 2-entry pixel FIFO as 4 packed 32-bit words per pixel.
// A capture shows on out_we one cycle later; out_we/out_data/out_addr hold while !out_ready, and a third pixel arriving with the FIFO full is dropped.
module ofm_drain #(
   parameter int NUM_PE  = 16,
   parameter int ADDR_W  = 16,
   parameter int NUM_PIX = 3136
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [NUM_PE-1:0]     PE_finish,
   input  logic [8*NUM_PE-1:0]   ofm_in,
   input  logic                  out_ready,
   output logic                  out_we,
   output logic [ADDR_W-1:0]     out_addr,
   output logic [31:0]           out_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err_partial,
   output logic                  err_overflow
);

   localparam int PIX_W    = $clog2(NUM_PIX + 1);
   localparam int PIX_BITS = 8 * NUM_PE;
   localparam logic [PIX_W-1:0] C_NUM_PIX = PIX_W'(NUM_PIX);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PIX_BITS-1:0]  r_ent [2];
   logic                 r_rd_ptr;
   logic [1:0]           r_cnt;
   logic [1:0]           r_word;
   logic [ADDR_W-1:0]    r_addr;
   logic [PIX_W-1:0]     r_pix_cnt;
   logic [PIX_W-1:0]     r_acc_cnt;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err_p;
   logic                 r_err_o;

   logic                 w_run;
   logic                 w_all;
   logic                 w_none;
   logic                 w_xfer;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_cap_req;
   logic                 w_push;
   logic                 w_ovf;
   logic                 w_part;
   logic                 w_wr_ptr;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;
   logic [PIX_BITS-1:0]  w_head;
   logic [31:0]          w_data;

   assign out_we       = (r_cnt != 2'd0);
   assign out_addr     = r_addr;
   assign out_data     = w_data;
   assign busy         = r_busy;
   assign done         = r_done;
   assign err_partial  = r_err_p;
   assign err_overflow = r_err_o;

   assign w_run     = (r_state == S_RUN);
   assign w_all     = &PE_finish;
   assign w_none    = ~|PE_finish;
   assign w_xfer    = out_we & out_ready;
   assign w_pop     = w_xfer & (r_word == 2'd3);
   assign w_full    = (r_cnt == 2'd2);
   // Once NUM_PIX pixels are accepted the layer is complete; later strobes are ignored.
   assign w_cap_req = w_run & ~start & w_all & (r_acc_cnt < C_NUM_PIX);
   assign w_push    = w_cap_req & (~w_full | w_pop);
   assign w_ovf     = w_cap_req & w_full & ~w_pop;
   assign w_part    = w_run & ~start & ~w_all & ~w_none;
   // With both slots full and the head popping, the freed head slot takes the new pixel.
   assign w_wr_ptr  = r_rd_ptr ^ r_cnt[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = S_RUN;
      end else begin
         case (r_state)
            S_RUN:   if ((r_pix_cnt == C_NUM_PIX) && (r_cnt == 2'd0)) w_state_nxt = S_DONE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      w_busy_nxt = (w_state_nxt == S_RUN);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   always_comb begin
      w_head = r_ent[r_rd_ptr];
      w_data = '0;
      for (int b = 0; b < 4; b++) begin
         w_data[31-8*b -: 8] = w_head[32*int'(r_word) + 8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ent[0]  <= '0;
         r_ent[1]  <= '0;
         r_rd_ptr  <= 1'b0;
         r_cnt     <= 2'd0;
         r_word    <= 2'd0;
         r_addr    <= '0;
         r_pix_cnt <= '0;
         r_acc_cnt <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err_p   <= 1'b0;
         r_err_o   <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         if (start) begin
            r_rd_ptr  <= 1'b0;
            r_cnt     <= 2'd0;
            r_word    <= 2'd0;
            r_addr    <= '0;
            r_pix_cnt <= '0;
            r_acc_cnt <= '0;
            r_err_p   <= 1'b0;
            r_err_o   <= 1'b0;
         end else begin
            if (w_xfer) begin
               r_addr <= r_addr + ADDR_W'(1);
               r_word <= r_word + 2'd1;
            end
            if (w_pop) begin
               r_rd_ptr  <= ~r_rd_ptr;
               r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            end
            if (w_push) begin
               r_ent[w_wr_ptr] <= ofm_in;
               r_acc_cnt       <= r_acc_cnt + PIX_W'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_cnt <= r_cnt + 2'd1;
               2'b01:   r_cnt <= r_cnt - 2'd1;
               default: r_cnt <= r_cnt;
            endcase
            if (w_part) r_err_p <= 1'b1;
            if (w_ovf)  r_err_o <= 1'b1;
         end
      end
   end

endmodule
